ex_stage: RTL and testbench

- Execute stage of the MIPS-lite pipeline. Sits between the ID stage and the mem stage.
- Takes the decoded opcode, operand values, immediate and destination register from ID, and computes the ALU result, memory address and store data.
- Resolves branches and jumps. Registers the mem-stage control and data inputs.
- Contains an iterative multiplier that stalls upstream while it runs.

---
 rtl/ex_stage_if.sv | 34 +++
 rtl/ex_stage.sv | 127 ++++++++++++
 tb/tb_ex_stage.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID-side instruction inputs and mem/IF-side results of the execute stage
interface ex_stage_if #(
    parameter int D_SIZE = 32,
    parameter int ADDR_LINE_MEM = 10,
    parameter int ADDR_LINE_REG = 5
);
    logic valid_in;
    logic [5:0] opcode;
    logic [D_SIZE-1:0] rs_val;
    logic [D_SIZE-1:0] rt_val;
    logic [15:0] imm;
    logic [ADDR_LINE_REG-1:0] rd_addr;
    logic [D_SIZE-1:0] pc_in;
    logic stall_out;
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
    logic [ADDR_LINE_MEM-1:0] addr_in;
    logic [ADDR_LINE_REG-1:0] addr_reg_in;
    logic [D_SIZE-1:0] write_data;
    logic branch_taken;
    logic [D_SIZE-1:0] branch_target;
    logic halt_out;
    modport master(
        output valid_in, opcode, rs_val, rt_val, imm, rd_addr, pc_in,
        input stall_out, mem_write, mem_read, mem_to_reg, addr_in, addr_reg_in,
        write_data, branch_taken, branch_target, halt_out
    );
    modport slave(
        input valid_in, opcode, rs_val, rt_val, imm, rd_addr, pc_in,
        output stall_out, mem_write, mem_read, mem_to_reg, addr_in, addr_reg_in,
        write_data, branch_taken, branch_target, halt_out
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: MIPS-lite execute stage; ALU, address generation, branch resolution, iterative multiplier
module ex_stage #(
    parameter int D_SIZE = 32,
    parameter int ADDR_LINE_MEM = 10,
    parameter int ADDR_LINE_REG = 5,
    parameter int MUL_STEP = 8
) (
    input logic clk,
    input logic reset,
    ex_stage_if.slave bus
);
    localparam int STEPS = D_SIZE / MUL_STEP;
    localparam int CW = $clog2(STEPS + 1);
    typedef enum logic [1:0] {IDLE, MUL_BUSY, HALTED} state_t;
    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [D_SIZE-1:0] acc, acc_d, ma, ma_d, mb, mb_d, acc_n;
    logic [ADDR_LINE_REG-1:0] mrd, mrd_d;
    logic [D_SIZE-1:0] sx, opb, res, wd_d, bt_d;
    logic [ADDR_LINE_MEM-1:0] ad_d;
    logic [ADDR_LINE_REG-1:0] ard_d;
    logic mw_d, mr_d, m2r_d, br_d, halt_d;
    logic v, is_mul, is_mem, is_br, taken;
    assign bus.stall_out = state == MUL_BUSY;
    always_comb begin
        sx = {{(D_SIZE-16){bus.imm[15]}}, bus.imm};
        v = bus.valid_in && bus.opcode <= 6'h11;
        is_mul = bus.opcode[5:1] == 5'h02;
        is_mem = bus.opcode[5:1] == 5'h06;
        is_br = bus.opcode >= 6'h0E && bus.opcode <= 6'h10;
        opb = (bus.opcode[0] || is_mem) ? sx : bus.rt_val;
        res = bus.opcode[4:1] == 4'h1 ? bus.rs_val - opb :
              bus.opcode[4:1] == 4'h3 ? bus.rs_val | opb :
              bus.opcode[4:1] == 4'h4 ? bus.rs_val & opb :
              bus.opcode[4:1] == 4'h5 ? bus.rs_val ^ opb : bus.rs_val + opb;
        taken = bus.opcode == 6'h10 ||
                (bus.opcode == 6'h0E ? bus.rs_val == '0 : bus.rs_val == bus.rt_val);
        // one MUL_STEP-bit slice of the multiplier per cycle; operands shift as slices retire
        acc_n = acc + ma * {{(D_SIZE-MUL_STEP){1'b0}}, mb[MUL_STEP-1:0]};
        state_d = state;
        cnt_d = cnt;
        acc_d = acc;
        ma_d = ma;
        mb_d = mb;
        mrd_d = mrd;
        mw_d = 1'b0;
        mr_d = 1'b0;
        m2r_d = 1'b0;
        br_d = 1'b0;
        wd_d = bus.write_data;
        ad_d = bus.addr_in;
        ard_d = bus.addr_reg_in;
        bt_d = bus.branch_target;
        halt_d = bus.halt_out;
        if (state == IDLE && v) begin
            if (is_mul) begin
                ma_d = bus.rs_val;
                mb_d = opb;
                mrd_d = bus.rd_addr;
                cnt_d = CW'(STEPS);
                acc_d = '0;
                state_d = MUL_BUSY;
            end else if (bus.opcode == 6'h11) begin
                state_d = HALTED;
                halt_d = 1'b1;
            end else if (is_br) begin
                br_d = taken;
                bt_d = !taken ? bus.branch_target :
                       bus.opcode == 6'h10 ? bus.rs_val : bus.pc_in + (sx << 2);
            end else begin
                wd_d = bus.opcode == 6'h0D ? bus.rt_val : res;
                ad_d = res[ADDR_LINE_MEM+1:2];
                ard_d = bus.rd_addr;
                mw_d = bus.opcode == 6'h0D;
                mr_d = bus.opcode == 6'h0C;
                m2r_d = bus.opcode != 6'h0D;
            end
        end else if (state == MUL_BUSY) begin
            acc_d = acc_n;
            ma_d = ma << MUL_STEP;
            mb_d = mb >> MUL_STEP;
            cnt_d = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                wd_d = acc_n;
                ad_d = acc_n[ADDR_LINE_MEM+1:2];
                ard_d = mrd;
                m2r_d = 1'b1;
                state_d = IDLE;
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            ma <= '0;
            mb <= '0;
            mrd <= '0;
            bus.mem_write <= 1'b0;
            bus.mem_read <= 1'b0;
            bus.mem_to_reg <= 1'b0;
            bus.branch_taken <= 1'b0;
            bus.write_data <= '0;
            bus.addr_in <= '0;
            bus.addr_reg_in <= '0;
            bus.branch_target <= '0;
            bus.halt_out <= 1'b0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            acc <= acc_d;
            ma <= ma_d;
            mb <= mb_d;
            mrd <= mrd_d;
            bus.mem_write <= mw_d;
            bus.mem_read <= mr_d;
            bus.mem_to_reg <= m2r_d;
            bus.branch_taken <= br_d;
            bus.write_data <= wd_d;
            bus.addr_in <= ad_d;
            bus.addr_reg_in <= ard_d;
            bus.branch_target <= bt_d;
            bus.halt_out <= halt_d;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table vectors, multiply/reset/halt sequences and a randomized reference-model run
module tb_ex_stage;
    localparam int D = 32, AM = 10, AR = 5;
    logic clk = 1'b0, reset = 1'b0;
    ex_stage_if #(.D_SIZE(D), .ADDR_LINE_MEM(AM), .ADDR_LINE_REG(AR)) bus();
    ex_stage #(.D_SIZE(D), .ADDR_LINE_MEM(AM), .ADDR_LINE_REG(AR), .MUL_STEP(8))
        dut(.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    int vectors = 0, miscompares = 0;
    logic [D-1:0] e_wd, e_bt;
    logic [AM-1:0] e_ad;
    logic [AR-1:0] e_ard;
    logic e_mw, e_mr, e_m2r, e_br, e_halt, e_stall;
    typedef struct {
        logic v; logic [5:0] op; logic [31:0] rs, rt; logic [15:0] imm; logic [4:0] rd; logic [31:0] pc;
        logic mw, mr, m2r; logic [31:0] wd; logic [9:0] ad; logic [4:0] ard; logic br; logic [31:0] bt;
    } vec_t;
    vec_t tbl[16];
    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    task automatic check_all(string t);
        chk({t, ".mem_write"}, 64'(bus.mem_write), 64'(e_mw));
        chk({t, ".mem_read"}, 64'(bus.mem_read), 64'(e_mr));
        chk({t, ".mem_to_reg"}, 64'(bus.mem_to_reg), 64'(e_m2r));
        chk({t, ".write_data"}, 64'(bus.write_data), 64'(e_wd));
        chk({t, ".addr_in"}, 64'(bus.addr_in), 64'(e_ad));
        chk({t, ".addr_reg_in"}, 64'(bus.addr_reg_in), 64'(e_ard));
        chk({t, ".branch_taken"}, 64'(bus.branch_taken), 64'(e_br));
        chk({t, ".branch_target"}, 64'(bus.branch_target), 64'(e_bt));
        chk({t, ".halt_out"}, 64'(bus.halt_out), 64'(e_halt));
        chk({t, ".stall_out"}, 64'(bus.stall_out), 64'(e_stall));
    endtask
    task automatic drive(logic v, logic [5:0] op, logic [31:0] rs, logic [31:0] rt,
                         logic [15:0] imm, logic [4:0] rd, logic [31:0] pc);
        bus.valid_in = v; bus.opcode = op; bus.rs_val = rs; bus.rt_val = rt;
        bus.imm = imm; bus.rd_addr = rd; bus.pc_in = pc;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic clear_model();
        {e_mw, e_mr, e_m2r, e_br, e_halt, e_stall} = '0;
        e_wd = '0; e_bt = '0; e_ad = '0; e_ard = '0;
    endtask
    task automatic bubble(logic stall);
        {e_mw, e_mr, e_m2r, e_br} = '0;
        e_stall = stall;
    endtask
    // architectural effect of one accepted instruction in an idle, un-halted stage
    task automatic model(logic v, logic [5:0] op, logic [31:0] rs, logic [31:0] rt,
                         logic [15:0] imm, logic [4:0] rd, logic [31:0] pc);
        logic [31:0] sx, r;
        bubble(1'b0);
        if (!v || op > 6'h11) return;
        sx = {{16{imm[15]}}, imm};
        case (op)
            6'h00: r = rs + rt;   6'h01: r = rs + sx;
            6'h02: r = rs - rt;   6'h03: r = rs - sx;
            6'h04: r = rs * rt;   6'h05: r = rs * sx;
            6'h06: r = rs | rt;   6'h07: r = rs | sx;
            6'h08: r = rs & rt;   6'h09: r = rs & sx;
            6'h0A: r = rs ^ rt;   6'h0B: r = rs ^ sx;
            default: r = rs + sx;
        endcase
        if (op <= 6'h0D) begin
            e_wd = op == 6'h0D ? rt : r;
            e_ad = r[AM+1:2];
            e_ard = rd;
            e_mw = op == 6'h0D;
            e_mr = op == 6'h0C;
            e_m2r = op != 6'h0D;
        end else if (op == 6'h11) e_halt = 1'b1;
        else if (op == 6'h10) begin e_br = 1'b1; e_bt = rs; end
        else if (op == 6'h0E ? rs == 0 : rs == rt) begin e_br = 1'b1; e_bt = pc + sx * 4; end
    endtask
    initial begin
        logic v;
        logic [5:0] op;
        logic [31:0] rs, rt, pc;
        logic [15:0] imm;
        logic [4:0] rd;
        tbl[0]  = '{1, 6'h00, 5, 7, 0, 3, 0,            0, 0, 1, 12, 3, 3, 0, 0};
        tbl[1]  = '{1, 6'h0D, 'h100, 'hDEAD, 8, 4, 0,   1, 0, 0, 'hDEAD, 'h42, 4, 0, 0};
        tbl[2]  = '{1, 6'h0C, 'h100, 'hDEAD, 8, 4, 0,   0, 1, 1, 'h108, 'h42, 4, 0, 0};
        tbl[3]  = '{1, 6'h03, 0, 0, 'hFFFF, 5, 0,       0, 0, 1, 1, 0, 5, 0, 0};
        tbl[4]  = '{1, 6'h01, 'h7FFFFFFF, 0, 1, 6, 0,   0, 0, 1, 'h80000000, 0, 6, 0, 0};
        tbl[5]  = '{1, 6'h0F, 9, 9, 3, 1, 'h40,         0, 0, 0, 'h80000000, 0, 6, 1, 'h4C};
        tbl[6]  = '{1, 6'h0E, 1, 0, 3, 1, 'h40,         0, 0, 0, 'h80000000, 0, 6, 0, 'h4C};
        tbl[7]  = '{1, 6'h10, 'h200, 0, 0, 1, 'h80,     0, 0, 0, 'h80000000, 0, 6, 1, 'h200};
        tbl[8]  = '{0, 6'h00, 1, 1, 0, 2, 0,            0, 0, 0, 'h80000000, 0, 6, 0, 'h200};
        tbl[9]  = '{1, 6'h12, 1, 1, 0, 2, 0,            0, 0, 0, 'h80000000, 0, 6, 0, 'h200};
        tbl[10] = '{1, 6'h0A, 'hF0F0, 'hFF00, 0, 7, 0,  0, 0, 1, 'h0FF0, 'h3FC, 7, 0, 'h200};
        tbl[11] = '{1, 6'h09, 'hFFFF1234, 0, 'h8F0F, 8, 0, 0, 0, 1, 'hFFFF0204, 'h81, 8, 0, 'h200};
        tbl[12] = '{1, 6'h07, 'h10, 0, 1, 9, 0,         0, 0, 1, 'h11, 4, 9, 0, 'h200};
        tbl[13] = '{1, 6'h02, 3, 5, 0, 10, 0,           0, 0, 1, 'hFFFFFFFE, 'h3FF, 10, 0, 'h200};
        tbl[14] = '{1, 6'h0F, 1, 2, 3, 1, 'h40,         0, 0, 0, 'hFFFFFFFE, 'h3FF, 10, 0, 'h200};
        tbl[15] = '{1, 6'h0E, 0, 0, 'hFFFF, 1, 'h100,   0, 0, 0, 'hFFFFFFFE, 'h3FF, 10, 1, 'hFC};
        drive(0, 0, 0, 0, 0, 0, 0);
        clear_model();
        step(); step();
        check_all("reset");
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].imm, tbl[i].rd, tbl[i].pc);
            step();
            {e_mw, e_mr, e_m2r, e_wd, e_ad, e_ard, e_br, e_bt} =
                {tbl[i].mw, tbl[i].mr, tbl[i].m2r, tbl[i].wd, tbl[i].ad, tbl[i].ard, tbl[i].br, tbl[i].bt};
            e_stall = 1'b0;
            check_all($sformatf("tbl%0d", i));
        end
        drive(1, 6'h05, 32'hFFFFFFFD, 0, 7, 11, 0);
        step();
        bubble(1'b1);
        check_all("muli.n");
        drive(1, 6'h00, 1, 2, 0, 12, 0);
        for (int k = 1; k < 4; k++) begin step(); check_all($sformatf("muli.n%0d", k)); end
        step();
        bubble(1'b0);
        e_m2r = 1'b1; e_wd = 32'hFFFFFFEB; e_ad = 10'h3FA; e_ard = 11;
        check_all("muli.result");
        step();
        model(1, 6'h00, 1, 2, 0, 12, 0);
        check_all("add_after_mul");
        drive(1, 6'h04, 6, 7, 0, 13, 0);
        step(); step(); step();
        reset = 1'b0;
        #1;
        clear_model();
        check_all("mul_abort");
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk) reset = 1'b1;
        for (int k = 0; k < 4; k++) begin step(); check_all($sformatf("mul_abort.after%0d", k)); end
        for (int i = 0; i < 300; i++) begin
            v = $urandom_range(0, 7) != 0;
            op = 6'($urandom_range(0, 19));
            if (op == 6'h11) op = 6'h00;
            rs = $urandom_range(0, 5) == 0 ? 0 : $urandom;
            rt = $urandom_range(0, 3) == 0 ? rs : $urandom;
            imm = 16'($urandom);
            rd = 5'($urandom);
            pc = $urandom & 32'hFFFF_FFFC;
            drive(v, op, rs, rt, imm, rd, pc);
            if (v && (op == 6'h04 || op == 6'h05)) begin
                bubble(1'b1);
                for (int k = 0; k < 4; k++) begin step(); check_all("rnd.mulbusy"); end
                drive(0, 0, 0, 0, 0, 0, 0);
                model(v, op, rs, rt, imm, rd, pc);
                step();
                check_all("rnd.mul");
            end else begin
                model(v, op, rs, rt, imm, rd, pc);
                step();
                check_all("rnd");
            end
        end
        drive(1, 6'h11, 0, 0, 0, 0, 0);
        step();
        bubble(1'b0);
        e_halt = 1'b1;
        check_all("halt");
        drive(1, 6'h00, 4, 4, 0, 2, 0);
        for (int k = 0; k < 3; k++) begin step(); check_all($sformatf("halted%0d", k)); end
        reset = 1'b0;
        #1;
        clear_model();
        check_all("halt_reset");
        @(negedge clk) reset = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
